// File: rtl/quiz_round_control.sv
// Quiz game-play engine: latches settings on start, arbitrates buzzers, runs the
// per-question answer countdown, applies host judgements and declares a winner.
module quiz_round_control #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] buzz_i,
  input  logic       judge_ok_i,
  input  logic       judge_fail_i,
  input  logic [2:0] player_count_i,
  input  logic [3:0] question_count_i,
  input  logic [6:0] answer_time_i,
  input  logic [6:0] win_score_i,
  input  logic [3:0] success_score_i,
  input  logic [3:0] fail_score_i,
  output logic [2:0] state_o,
  output logic [3:0] question_no_o,
  output logic [1:0] responder_o,
  output logic [6:0] countdown_o,
  output logic [6:0] score0_o,
  output logic [6:0] score1_o,
  output logic [6:0] score2_o,
  output logic [6:0] score3_o,
  output logic [2:0] winner_o
);

  localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReady  = 3'd1,
    StAnswer = 3'd2,
    StResult = 3'd3,
    StOver   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       buzz_q;
  logic [2:0]       players_q, players_d;
  logic [3:0]       questions_q, questions_d;
  logic [6:0]       ans_time_q, ans_time_d;
  logic [6:0]       win_q, win_d;
  logic [3:0]       succ_q, succ_d;
  logic [3:0]       fail_q, fail_d;
  logic [3:0]       question_q, question_d;
  logic [1:0]       responder_q, responder_d;
  logic [6:0]       countdown_q, countdown_d;
  logic [6:0]       score_q [4];
  logic [6:0]       score_d [4];
  logic [2:0]       winner_q, winner_d;
  logic [TickW-1:0] tick_q, tick_d;

  logic [3:0] buzz_edge, active, elig;
  logic [1:0] pick;
  logic       tick_wrap, any_win, best_tie;
  logic [6:0] best_val;
  logic [1:0] best_idx;

  function automatic logic [6:0] add_sat(input logic [6:0] a, input logic [3:0] b);
    logic [7:0] s;
    s = {1'b0, a} + {4'b0000, b};
    return (s > 8'd99) ? 7'd99 : s[6:0];
  endfunction

  function automatic logic [6:0] sub_floor(input logic [6:0] a, input logic [3:0] b);
    logic [7:0] s;
    s = {1'b0, a} - {4'b0000, b};
    return (a < {3'b000, b}) ? 7'd0 : s[6:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      buzz_q      <= '0;
      players_q   <= '0;
      questions_q <= '0;
      ans_time_q  <= '0;
      win_q       <= '0;
      succ_q      <= '0;
      fail_q      <= '0;
      question_q  <= '0;
      responder_q <= '0;
      countdown_q <= '0;
      winner_q    <= '0;
      tick_q      <= '0;
      for (int i = 0; i < 4; i++) score_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      buzz_q      <= buzz_i;
      players_q   <= players_d;
      questions_q <= questions_d;
      ans_time_q  <= ans_time_d;
      win_q       <= win_d;
      succ_q      <= succ_d;
      fail_q      <= fail_d;
      question_q  <= question_d;
      responder_q <= responder_d;
      countdown_q <= countdown_d;
      winner_q    <= winner_d;
      tick_q      <= tick_d;
      for (int i = 0; i < 4; i++) score_q[i] <= score_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    players_d   = players_q;
    questions_d = questions_q;
    ans_time_d  = ans_time_q;
    win_d       = win_q;
    succ_d      = succ_q;
    fail_d      = fail_q;
    question_d  = question_q;
    responder_d = responder_q;
    countdown_d = countdown_q;
    winner_d    = winner_q;
    tick_d      = tick_q;
    for (int i = 0; i < 4; i++) score_d[i] = score_q[i];

    buzz_edge = buzz_i & ~buzz_q;
    for (int i = 0; i < 4; i++) active[i] = (3'(i) < players_q);
    elig = buzz_edge & active;
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) pick = 2'(i);
    end
    tick_wrap = (tick_q == TickLast);

    any_win = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (score_q[i] >= win_q) any_win = 1'b1;
    end
    // Player 0 is always active, so it seeds the maximum search.
    best_val = score_q[0];
    best_idx = 2'd0;
    best_tie = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (active[i]) begin
        if (score_q[i] > best_val) begin
          best_val = score_q[i];
          best_idx = 2'(i);
          best_tie = 1'b0;
        end else if (score_q[i] == best_val) begin
          best_tie = 1'b1;
        end
      end
    end

    case (state_q)
      StIdle, StOver: begin
        if (start_i) begin
          players_d   = player_count_i;
          questions_d = question_count_i;
          ans_time_d  = answer_time_i;
          win_d       = win_score_i;
          succ_d      = success_score_i;
          fail_d      = fail_score_i;
          for (int i = 0; i < 4; i++) score_d[i] = '0;
          winner_d    = '0;
          question_d  = 4'd1;
          countdown_d = '0;
          state_d     = StReady;
        end
      end
      StReady: begin
        if (|elig) begin
          responder_d = pick;
          countdown_d = ans_time_q;
          tick_d      = '0;
          state_d     = StAnswer;
        end else if (judge_fail_i) begin
          tick_d  = '0;
          state_d = StResult;
        end
      end
      StAnswer: begin
        if (tick_wrap) begin
          tick_d = '0;
          if (countdown_q != 7'd0) countdown_d = countdown_q - 7'd1;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
        if (judge_ok_i) begin
          score_d[responder_q] = add_sat(score_q[responder_q], succ_q);
          tick_d  = '0;
          state_d = StResult;
        end else if (judge_fail_i || (tick_wrap && countdown_q == 7'd1)) begin
          score_d[responder_q] = sub_floor(score_q[responder_q], fail_q);
          tick_d  = '0;
          state_d = StResult;
        end
      end
      StResult: begin
        if (tick_wrap) begin
          tick_d = '0;
          if (any_win) begin
            winner_d = {1'b0, responder_q} + 3'd1;
            state_d  = StOver;
          end else if (question_q == questions_q) begin
            winner_d = best_tie ? 3'd0 : ({1'b0, best_idx} + 3'd1);
            state_d  = StOver;
          end else begin
            question_d  = question_q + 4'd1;
            countdown_d = '0;
            state_d     = StReady;
          end
        end else begin
          tick_d = tick_q + TickW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    state_o       = state_q;
    question_no_o = question_q;
    responder_o   = responder_q;
    countdown_o   = countdown_q;
    score0_o      = score_q[0];
    score1_o      = score_q[1];
    score2_o      = score_q[2];
    score3_o      = score_q[3];
    winner_o      = winner_q;
  end

endmodule

// File: tb/tb_quiz_round_control.sv
// Bench for quiz_round_control: scripted game table, targeted corner sequences and a
// randomized run checked against a cycle-level behavioural game model.
module tb_quiz_round_control;

  localparam int unsigned T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, judge_ok = 1'b0, judge_fail = 1'b0;
  logic [3:0] buzz = '0;
  logic [2:0] set_pc = 3'd2;
  logic [3:0] set_qc = 4'd5;
  logic [6:0] set_at = 7'd10, set_ws = 7'd3;
  logic [3:0] set_ss = 4'd1, set_fs = 4'd1;
  logic [2:0] state, winner;
  logic [3:0] question_no;
  logic [1:0] responder;
  logic [6:0] countdown, sc0, sc1, sc2, sc3;

  always #5 clk = ~clk;

  quiz_round_control #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst(rst), .start_i(start), .buzz_i(buzz),
    .judge_ok_i(judge_ok), .judge_fail_i(judge_fail),
    .player_count_i(set_pc), .question_count_i(set_qc), .answer_time_i(set_at),
    .win_score_i(set_ws), .success_score_i(set_ss), .fail_score_i(set_fs),
    .state_o(state), .question_no_o(question_no), .responder_o(responder),
    .countdown_o(countdown), .score0_o(sc0), .score1_o(sc1), .score2_o(sc2),
    .score3_o(sc3), .winner_o(winner)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: elapsed-cycle counts per phase, plain integer score rules.
  int m_state, m_q, m_resp, m_cd, m_win, m_el;
  int m_sc [4];
  int l_pc, l_qc, l_at, l_ws, l_ss, l_fs;
  logic [3:0] m_prev;

  task automatic model_step(input logic r, input logic s, input logic [3:0] b,
                            input logic ok, input logic f);
    logic [3:0] e;
    int mx, cnt, idx;
    bit any;
    if (r) begin
      m_state = 0; m_q = 0; m_resp = 0; m_cd = 0; m_win = 0; m_el = 0; m_prev = '0;
      for (int i = 0; i < 4; i++) m_sc[i] = 0;
      return;
    end
    e = b & ~m_prev;
    m_prev = b;
    case (m_state)
      0, 4: if (s) begin
        l_pc = int'(set_pc); l_qc = int'(set_qc); l_at = int'(set_at);
        l_ws = int'(set_ws); l_ss = int'(set_ss); l_fs = int'(set_fs);
        for (int i = 0; i < 4; i++) m_sc[i] = 0;
        m_win = 0; m_q = 1; m_cd = 0; m_state = 1;
      end
      1: begin
        idx = -1;
        for (int i = l_pc - 1; i >= 0; i--) if (e[i]) idx = i;
        if (idx >= 0) begin
          m_resp = idx; m_cd = l_at; m_el = 0; m_state = 2;
        end else if (f) begin
          m_el = 0; m_state = 3;
        end
      end
      2: begin
        m_el++;
        m_cd = l_at - m_el / int'(T);
        if (ok) begin
          m_sc[m_resp] = (m_sc[m_resp] + l_ss > 99) ? 99 : m_sc[m_resp] + l_ss;
          m_state = 3; m_el = 0;
        end else if (f || m_el == l_at * int'(T)) begin
          m_sc[m_resp] = (m_sc[m_resp] - l_fs < 0) ? 0 : m_sc[m_resp] - l_fs;
          m_state = 3; m_el = 0;
        end
      end
      3: begin
        m_el++;
        if (m_el == int'(T)) begin
          any = 0;
          for (int i = 0; i < 4; i++) if (m_sc[i] >= l_ws) any = 1;
          if (any) begin
            m_state = 4; m_win = m_resp + 1;
          end else if (m_q == l_qc) begin
            mx = 0; cnt = 0; idx = 0;
            for (int i = 0; i < l_pc; i++) if (m_sc[i] > mx) mx = m_sc[i];
            for (int i = 0; i < l_pc; i++) if (m_sc[i] == mx) begin cnt++; idx = i; end
            m_state = 4; m_win = (cnt == 1) ? idx + 1 : 0;
          end else begin
            m_q++; m_cd = 0; m_state = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic apply(input logic r, input logic s, input logic [3:0] b,
                       input logic ok, input logic f);
    rst = r; start = s; buzz = b; judge_ok = ok; judge_fail = f;
    model_step(r, s, b, ok, f);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] b);
    for (int k = 0; k < n; k++) apply(1'b0, 1'b0, b, 1'b0, 1'b0);
  endtask

  task automatic compare_model(input int cyc);
    string p;
    p = $sformatf("rand%0d", cyc);
    check({p, " state"}, int'(state), m_state);
    check({p, " question_no"}, int'(question_no), m_q);
    check({p, " responder"}, int'(responder), m_resp);
    check({p, " countdown"}, int'(countdown), m_cd);
    check({p, " score0"}, int'(sc0), m_sc[0]);
    check({p, " score1"}, int'(sc1), m_sc[1]);
    check({p, " score2"}, int'(sc2), m_sc[2]);
    check({p, " score3"}, int'(sc3), m_sc[3]);
    check({p, " winner"}, int'(winner), m_win);
  endtask

  typedef struct {
    logic r, s; logic [3:0] b; logic ok, f; int n;
    int st, q, rsp, cd, s0, s1, w;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] b,
                              input logic ok, input logic f, input int n, input int st,
                              input int q, input int rsp, input int cd, input int s0,
                              input int s1, input int w);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.ok = ok; v.f = f; v.n = n;
    v.st = st; v.q = q; v.rsp = rsp; v.cd = cd; v.s0 = s0; v.s1 = s1; v.w = w;
    return v;
  endfunction

  vec_t tbl [$];
  int   lat;
  logic [3:0] rb;

  initial begin
    // Settings: players 2, questions 5, time 10, win 3, succ 1, fail 1.
    //            r  s  buzz     ok f  n   st q rsp cd s0 s1 w
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 2,  0, 0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 1,  1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0011, 0, 0, 1,  2, 1, 0, 10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0011, 1, 0, 1,  3, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 9,  3, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1,  1, 2, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b1000, 0, 0, 2,  1, 2, 0, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 0, 0, 1,  2, 2, 1, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 9,  2, 2, 1, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1,  2, 2, 1, 9,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 89, 2, 2, 1, 1,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1,  3, 2, 1, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 10, 1, 3, 1, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 3,  1, 3, 1, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1,  1, 3, 1, 0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 1,  2, 3, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 1, 0, 1,  3, 3, 0, 10, 2, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 10, 1, 4, 0, 0,  2, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 1,  2, 4, 0, 10, 2, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 1, 0, 1,  3, 4, 0, 10, 3, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 10, 4, 4, 0, 10, 3, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1,  4, 4, 0, 10, 3, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 1,  1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 1, 1,  3, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 10, 1, 2, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 0, 1, 1,  2, 2, 1, 10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 1, 1, 1,  3, 2, 1, 10, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        apply(tbl[i].r, (k == 0) ? tbl[i].s : 1'b0, tbl[i].b,
              (k == 0) ? tbl[i].ok : 1'b0, (k == 0) ? tbl[i].f : 1'b0);
      check($sformatf("row%0d state", i), int'(state), tbl[i].st);
      check($sformatf("row%0d question_no", i), int'(question_no), tbl[i].q);
      check($sformatf("row%0d responder", i), int'(responder), tbl[i].rsp);
      check($sformatf("row%0d countdown", i), int'(countdown), tbl[i].cd);
      check($sformatf("row%0d score0", i), int'(sc0), tbl[i].s0);
      check($sformatf("row%0d score1", i), int'(sc1), tbl[i].s1);
      check($sformatf("row%0d winner", i), int'(winner), tbl[i].w);
    end

    // Timeout with answer_time 2: RESULT exactly 20 cycles after entering ANSWER.
    set_at = 7'd2;
    apply(1, 0, 4'b0000, 0, 0);
    apply(0, 1, 4'b0000, 0, 0);
    apply(0, 0, 4'b0010, 0, 0);
    check("timeout entry state", int'(state), 2);
    check("timeout entry countdown", int'(countdown), 2);
    lat = 0;
    for (int k = 1; k <= 50 && lat == 0; k++) begin
      apply(0, 0, 4'b0010, 0, 0);
      if (k == 10) check("timeout countdown mid", int'(countdown), 1);
      if (state != 3'd2) lat = k;
    end
    check("timeout latency", lat, 20);
    check("timeout state", int'(state), 3);
    check("timeout countdown end", int'(countdown), 0);
    check("timeout score1 floor", int'(sc1), 0);

    // Single question skipped with all scores 0 -> tie.
    set_pc = 3'd3; set_qc = 4'd1; set_at = 7'd5;
    apply(1, 0, 4'b0000, 0, 0);
    apply(0, 1, 4'b0000, 0, 0);
    apply(0, 0, 4'b0000, 0, 1);
    check("skip state", int'(state), 3);
    idle(10, 4'b0000);
    check("tie state", int'(state), 4);
    check("tie winner", int'(winner), 0);

    // Last question with a unique leader (player 2).
    set_qc = 4'd2; set_ws = 7'd5;
    apply(1, 0, 4'b0000, 0, 0);
    apply(0, 1, 4'b0000, 0, 0);
    apply(0, 0, 4'b0100, 0, 0);
    check("p2 responder", int'(responder), 2);
    apply(0, 0, 4'b0100, 1, 0);
    check("p2 score", int'(sc2), 1);
    idle(10, 4'b0000);
    check("p2 next question", int'(question_no), 2);
    apply(0, 0, 4'b0000, 0, 1);
    idle(10, 4'b0000);
    check("leader state", int'(state), 4);
    check("leader winner", int'(winner), 3);

    // Settings changed after start must not take effect.
    set_pc = 3'd2; set_qc = 4'd5; set_ws = 7'd3; set_ss = 4'd2;
    apply(1, 0, 4'b0000, 0, 0);
    apply(0, 1, 4'b0000, 0, 0);
    set_ws = 7'd1; set_ss = 4'd5;
    apply(0, 0, 4'b0001, 0, 0);
    apply(0, 0, 4'b0001, 1, 0);
    check("latched success score", int'(sc0), 2);
    idle(10, 4'b0000);
    check("latched win score", int'(state), 1);

    // Reset mid-ANSWER.
    apply(0, 0, 4'b0001, 0, 0);
    idle(5, 4'b0001);
    apply(1, 0, 4'b0001, 0, 0);
    check("rst state", int'(state), 0);
    check("rst question_no", int'(question_no), 0);
    check("rst countdown", int'(countdown), 0);
    check("rst score0", int'(sc0), 0);
    check("rst responder", int'(responder), 0);
    check("rst winner", int'(winner), 0);

    // Randomized play against the model.
    set_ss = 4'd1;
    rb = '0;
    apply(1, 0, 4'b0000, 0, 0);
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        set_pc = 3'($urandom_range(2, 4));
        set_qc = 4'($urandom_range(1, 4));
        set_at = 7'($urandom_range(1, 3));
        set_ws = 7'($urandom_range(1, 6));
        set_ss = 4'($urandom_range(1, 4));
        set_fs = 4'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 5) == 0) rb = rb ^ (4'b0001 << $urandom_range(0, 3));
      apply($urandom_range(0, 599) == 0, $urandom_range(0, 29) == 0, rb,
            $urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0);
      compare_model(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
